// File: rtl/execute_stage.sv
//==============================================================================
// Module      : execute_stage
// Description : rv32i execute stage. Selects the ALU B operand, evaluates the
//               ALU operation and registers the result plus control into the
//               M-stage pipeline register. Shifts run iteratively, one bit per
//               cycle, and hold the decode stage via stallD while busy.
//               Optional macro FAST_SHIFT_EN: when defined, shifts become
//               single-cycle barrel shifts, no SHIFT state is built and
//               stallD is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

// ALU operation encoding shared with the decode stage.
typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
} alu_op_t;

module execute_stage #(
    parameter int DPW = 32,
    parameter int ADW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           validE,
    input  logic           flushE,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic           alusrcE,
    input  logic           regwriteE,
    input  alu_op_t        alu_ctrlE,
    input  logic [DPW-1:0] srcA,
    input  logic [DPW-1:0] Rd2E,
    input  logic [ADW-1:0] RdE,
    input  logic [DPW-1:0] immextE,
    output logic           stallD,
    output logic           validM,
    output logic           resultsrcM,
    output logic           memwriteM,
    output logic           regwriteM,
    output logic [DPW-1:0] aluresultM,
    output logic [DPW-1:0] writedataM,
    output logic [ADW-1:0] RdM
);

    // Shift amount field is always the low five bits of operand B.
    localparam int c_SHW = 5;

    logic [DPW-1:0]   w_srcB;
    logic [c_SHW-1:0] w_shamt;
    logic [DPW-1:0]   w_alu_result;

    assign w_srcB  = alusrcE ? immextE : Rd2E;
    assign w_shamt = w_srcB[c_SHW-1:0];

    // Single-cycle ALU; in the iterative build a shift only reaches this
    // path with shamt==0, where the result is simply srcA.
    always_comb begin
        w_alu_result = '0;
        case (alu_ctrlE)
            ALU_ADD: w_alu_result = srcA + w_srcB;
            ALU_SUB: w_alu_result = srcA - w_srcB;
            ALU_AND: w_alu_result = srcA & w_srcB;
            ALU_OR:  w_alu_result = srcA | w_srcB;
            ALU_XOR: w_alu_result = srcA ^ w_srcB;
            ALU_SLT: w_alu_result = ($signed(srcA) < $signed(w_srcB)) ?
                                    {{(DPW-1){1'b0}}, 1'b1} : '0;
`ifdef FAST_SHIFT_EN
            ALU_SLL: w_alu_result = srcA << w_shamt;
            ALU_SRL: w_alu_result = srcA >> w_shamt;
`else
            ALU_SLL: w_alu_result = srcA;
            ALU_SRL: w_alu_result = srcA;
`endif
            default: w_alu_result = '0;
        endcase
    end

`ifdef FAST_SHIFT_EN

    assign stallD = 1'b0;

    // M pipeline register: every op completes in one cycle; flush inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            validM     <= 1'b0;
            resultsrcM <= 1'b0;
            memwriteM  <= 1'b0;
            regwriteM  <= 1'b0;
            aluresultM <= '0;
            writedataM <= '0;
            RdM        <= '0;
        end else begin
            resultsrcM <= resultsrcE;
            aluresultM <= w_alu_result;
            writedataM <= Rd2E;
            RdM        <= RdE;
            if (flushE) begin
                validM    <= 1'b0;
                memwriteM <= 1'b0;
                regwriteM <= 1'b0;
            end else begin
                validM    <= validE;
                memwriteM <= memwriteE & validE;
                regwriteM <= regwriteE & validE;
            end
        end
    end

`else

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [c_SHW-1:0] r_cnt;
    logic [DPW-1:0]   r_acc;
    logic             r_dir;          // 1 = shift right
    logic             r_cap_resultsrc;
    logic             r_cap_memwrite;
    logic             r_cap_regwrite;
    logic [ADW-1:0]   r_cap_rd;
    logic [DPW-1:0]   r_cap_wdata;

    logic             w_is_shift;
    logic             w_start;
    logic             w_complete;
    logic [DPW-1:0]   w_acc_next;

    assign w_is_shift = (alu_ctrlE == ALU_SLL) || (alu_ctrlE == ALU_SRL);
    assign w_acc_next = r_dir ? (r_acc >> 1) : (r_acc << 1);

    // Next-state and stall decode; flush overrides both start and completion.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_complete   = 1'b0;
        stallD       = 1'b0;
        case (r_state)
            IDLE: begin
                if (validE && w_is_shift && (w_shamt != '0) && !flushE) begin
                    w_start      = 1'b1;
                    stallD       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (flushE) begin
                    w_state_next = IDLE;
                end else if (r_cnt == 5'd1) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    stallD       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (flushE) begin
            w_state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift datapath: capture on start, one bit per cycle while in SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_acc           <= '0;
            r_dir           <= 1'b0;
            r_cap_resultsrc <= 1'b0;
            r_cap_memwrite  <= 1'b0;
            r_cap_regwrite  <= 1'b0;
            r_cap_rd        <= '0;
            r_cap_wdata     <= '0;
        end else if (flushE) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt           <= w_shamt;
            r_acc           <= srcA;
            r_dir           <= (alu_ctrlE == ALU_SRL);
            r_cap_resultsrc <= resultsrcE;
            r_cap_memwrite  <= memwriteE;
            r_cap_regwrite  <= regwriteE;
            r_cap_rd        <= RdE;
            r_cap_wdata     <= Rd2E;
        end else if (r_state == SHIFT) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // M pipeline register: normal load in IDLE, captured result on shift
    // completion, bubble control while a shift is starting or in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            validM     <= 1'b0;
            resultsrcM <= 1'b0;
            memwriteM  <= 1'b0;
            regwriteM  <= 1'b0;
            aluresultM <= '0;
            writedataM <= '0;
            RdM        <= '0;
        end else if (flushE) begin
            validM    <= 1'b0;
            memwriteM <= 1'b0;
            regwriteM <= 1'b0;
        end else if (w_complete) begin
            validM     <= 1'b1;
            resultsrcM <= r_cap_resultsrc;
            memwriteM  <= r_cap_memwrite;
            regwriteM  <= r_cap_regwrite;
            aluresultM <= w_acc_next;
            writedataM <= r_cap_wdata;
            RdM        <= r_cap_rd;
        end else if (w_start || (r_state == SHIFT)) begin
            validM    <= 1'b0;
            memwriteM <= 1'b0;
            regwriteM <= 1'b0;
        end else begin
            validM     <= validE;
            resultsrcM <= resultsrcE;
            memwriteM  <= memwriteE & validE;
            regwriteM  <= regwriteE & validE;
            aluresultM <= w_alu_result;
            writedataM <= Rd2E;
            RdM        <= RdE;
        end
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
//==============================================================================
// Module      : tb_execute_stage
// Description : Self-checking bench for execute_stage. Stimulus pushes the
//               expected M-stage contents and arrival cycle into a queue; a
//               monitor pops and compares whenever validM is seen.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_execute_stage;

    localparam int DPW = 32;
    localparam int ADW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           validE, flushE, resultsrcE, memwriteE, alusrcE, regwriteE;
    alu_op_t        alu_ctrlE;
    logic [DPW-1:0] srcA, Rd2E, immextE;
    logic [ADW-1:0] RdE;
    logic           stallD, validM, resultsrcM, memwriteM, regwriteM;
    logic [DPW-1:0] aluresultM, writedataM;
    logic [ADW-1:0] RdM;

    execute_stage #(.DPW(DPW), .ADW(ADW)) dut (
        .clk        (clk),
        .rst        (rst),
        .validE     (validE),
        .flushE     (flushE),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .alusrcE    (alusrcE),
        .regwriteE  (regwriteE),
        .alu_ctrlE  (alu_ctrlE),
        .srcA       (srcA),
        .Rd2E       (Rd2E),
        .RdE        (RdE),
        .immextE    (immextE),
        .stallD     (stallD),
        .validM     (validM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .regwriteM  (regwriteM),
        .aluresultM (aluresultM),
        .writedataM (writedataM),
        .RdM        (RdM)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        rs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every valid M-stage output against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (validM) begin
                if (q.size() == 0) begin
                    chk("unexpected_validM", {31'b0, validM}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("latency_cycle", cyc, mon_e.due);
                    chk("aluresultM", aluresultM, mon_e.res);
                    chk("writedataM", writedataM, mon_e.wd);
                    chk("RdM", {27'b0, RdM}, {27'b0, mon_e.rd});
                    chk("regwriteM", {31'b0, regwriteM}, {31'b0, mon_e.rw});
                    chk("memwriteM", {31'b0, memwriteM}, {31'b0, mon_e.mw});
                    chk("resultsrcM", {31'b0, resultsrcM}, {31'b0, mon_e.rs});
                end
            end else begin
                chk("bubble_regwriteM", {31'b0, regwriteM}, 32'd0);
                chk("bubble_memwriteM", {31'b0, memwriteM}, 32'd0);
            end
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("result_overdue", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        validE     = 1'b0;
        flushE     = 1'b0;
        resultsrcE = 1'b0;
        memwriteE  = 1'b0;
        alusrcE    = 1'b0;
        regwriteE  = 1'b0;
        alu_ctrlE  = ALU_ADD;
        srcA       = '0;
        Rd2E       = '0;
        immextE    = '0;
        RdE        = '0;
    endtask

    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic asrc, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic rs);
        validE     = 1'b1;
        flushE     = 1'b0;
        alu_ctrlE  = op;
        srcA       = a;
        Rd2E       = rd2;
        immextE    = imm;
        alusrcE    = asrc;
        RdE        = rd;
        regwriteE  = rw;
        memwriteE  = mw;
        resultsrcE = rs;
    endtask

    // Present one instruction, hold it while stallD is expected, and queue its result.
    task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic asrc, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic rs,
                         input logic [31:0] exp_res);
        logic [31:0] b;
        int          n;
        exp_t        e;
        b = asrc ? imm : rd2;
        n = ((op == ALU_SLL) || (op == ALU_SRL)) ? int'(b[4:0]) : 0;
        drive(op, a, rd2, imm, asrc, rd, rw, mw, rs);
        e.due = cyc + 1 + n;
        e.res = exp_res;
        e.wd  = rd2;
        e.rd  = rd;
        e.rw  = rw;
        e.mw  = mw;
        e.rs  = rs;
        q.push_back(e);
        for (int i = 0; i <= n; i++) begin
            #1;
            chk("stallD", {31'b0, stallD}, (i < n) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic check_m_zero(input string tag);
        chk({tag, "_validM"}, {31'b0, validM}, 32'd0);
        chk({tag, "_regwriteM"}, {31'b0, regwriteM}, 32'd0);
        chk({tag, "_memwriteM"}, {31'b0, memwriteM}, 32'd0);
        chk({tag, "_resultsrcM"}, {31'b0, resultsrcM}, 32'd0);
        chk({tag, "_aluresultM"}, aluresultM, 32'd0);
        chk({tag, "_writedataM"}, writedataM, 32'd0);
        chk({tag, "_RdM"}, {27'b0, RdM}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_m_zero("reset");
        chk("reset_stallD", {31'b0, stallD}, 32'd0);
        rst = 1'b0;

        // Basic ALU operations
        issue(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'd12);
        issue(ALU_SUB, 32'd0, 32'd0, 32'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'd1);
        issue(ALU_SLT, 32'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0);
        issue(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0000_F000);
        issue(ALU_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0000_FFF0);
        issue(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0000_0FF0);
        issue(ALU_ADD, 32'd100, 32'hCAFE_BABE, 32'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'd108);
        issue(alu_op_t'(4'hF), 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 32'd0);

        // Iterative shifts, back-to-back with a following instruction
        issue(ALU_SLL, 32'h1, 32'd0, 32'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 32'h10);
        issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 32'd3);
        issue(ALU_SRL, 32'h8000_0000, 32'd0, 32'd31, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 32'h1);
        issue(ALU_SRL, 32'h0000_00F0, 32'h0000_0023, 32'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 32'h0000_001E);
        issue(ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0020, 32'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Flush on the third cycle of an 8-bit shift
        drive(ALU_SLL, 32'h1, 32'd0, 32'd8, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
        #1; chk("flush_c0_stallD", {31'b0, stallD}, 32'd1);
        @(negedge clk);
        #1; chk("flush_c1_stallD", {31'b0, stallD}, 32'd1);
        @(negedge clk);
        flushE = 1'b1;
        #1; chk("flush_c2_stallD", {31'b0, stallD}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush_validM", {31'b0, validM}, 32'd0);
        chk("flush_regwriteM", {31'b0, regwriteM}, 32'd0);
        chk("flush_stallD", {31'b0, stallD}, 32'd0);
        @(negedge clk);
        issue(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 32'd5);

        // Bubble carrying write enables
        drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd18, 1'b1, 1'b1, 1'b1);
        validE = 1'b0;
        @(negedge clk);
        #1;
        chk("bubble_validM", {31'b0, validM}, 32'd0);
        chk("bubble_rw_gated", {31'b0, regwriteM}, 32'd0);
        chk("bubble_mw_gated", {31'b0, memwriteM}, 32'd0);

        // Reset in the middle of a shift clears everything in M
        issue(ALU_ADD, 32'h11, 32'h22, 32'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 32'h33);
        drive(ALU_SLL, 32'h3, 32'd0, 32'd5, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_m_zero("midshift_rst");
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        issue(ALU_ADD, 32'd40, 32'd2, 32'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, 32'd42);

        idle_inputs();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
